// File: rtl/ppu_bbus_if.sv
// Request/response handshake and PPU B-bus pins for the B-bus sequencer.
// The master modport is the sequencer side. The slave modport is the requester and pad side.
interface ppu_bbus_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [7:0] pa;
  logic [7:0] pd_out;
  logic       pd_oe;
  logic [7:0] pd_in;
  logic       pard_n;
  logic       pawr_n;
  logic       lvl_pa_dir;
  logic       lvl_pd_dir;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, pd_in,
    output req_ready, rsp_valid, rsp_rdata, pa, pd_out, pd_oe,
           pard_n, pawr_n, lvl_pa_dir, lvl_pd_dir
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, pd_in,
    input  req_ready, rsp_valid, rsp_rdata, pa, pd_out, pd_oe,
           pard_n, pawr_n, lvl_pa_dir, lvl_pd_dir
  );
endinterface

// File: rtl/ppu_bbus_master.sv
// Single-master PPU B-bus sequencer. It runs the phases SETUP, STROBE and HOLD with programmable cycle counts.
// All pin outputs are registered.
module ppu_bbus_master #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 2
) (
  input  logic      clock,
  input  logic      reset,
  ppu_bbus_if.master bus
);

  if (SETUP_CYCLES < 2 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("ppu_bbus_master: SETUP_CYCLES out of range 2..15");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("ppu_bbus_master: STROBE_CYCLES out of range 1..15");
  end
  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("ppu_bbus_master: HOLD_CYCLES out of range 2..15");
  end

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       wr_q;
  logic [7:0] pa_q, pd_out_q, rdata_q;
  logic       pd_oe_q, pard_n_q, pawr_n_q, pa_dir_q, pd_dir_q, rsp_q;

  assign bus.req_ready  = (state_q == IDLE) && !reset;
  assign bus.pa         = pa_q;
  assign bus.pd_out     = pd_out_q;
  assign bus.pd_oe      = pd_oe_q;
  assign bus.pard_n     = pard_n_q;
  assign bus.pawr_n     = pawr_n_q;
  assign bus.lvl_pa_dir = pa_dir_q;
  assign bus.lvl_pd_dir = pd_dir_q;
  assign bus.rsp_valid  = rsp_q;
  assign bus.rsp_rdata  = rdata_q;

  // cnt_q counts down to 0 within each phase and reloads on every phase change
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      pa_q     <= 8'h00;
      pd_out_q <= 8'h00;
      rdata_q  <= 8'h00;
      pd_oe_q  <= 1'b0;
      pard_n_q <= 1'b1;
      pawr_n_q <= 1'b1;
      pa_dir_q <= 1'b0;
      pd_dir_q <= 1'b0;
      rsp_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            state_q  <= SETUP;
            cnt_q    <= SETUP_LD;
            wr_q     <= bus.req_write;
            pa_q     <= bus.req_addr;
            pd_out_q <= bus.req_wdata;
            pa_dir_q <= 1'b1;
            pd_dir_q <= bus.req_write;
            // During the first setup cycle the shifter turns around, so the FPGA does not drive PD yet.
            pd_oe_q  <= 1'b0;
          end
        end
        SETUP: begin
          pd_oe_q <= wr_q;
          if (cnt_q == 4'd0) begin
            state_q  <= STROBE;
            cnt_q    <= STROBE_LD;
            pawr_n_q <= !wr_q;
            pard_n_q <= wr_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q  <= HOLD;
            cnt_q    <= HOLD_LD;
            pawr_n_q <= 1'b1;
            pard_n_q <= 1'b1;
            rsp_q    <= 1'b1;
            if (!wr_q) rdata_q <= bus.pd_in;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          rsp_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            state_q  <= IDLE;
            pa_dir_q <= 1'b0;
            pd_dir_q <= 1'b0;
            pd_oe_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            // Release PD one cycle before the direction flips back to input.
            if (cnt_q == 4'd1) pd_oe_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_bbus_master.sv
// Directed bench for ppu_bbus_master. It covers default timing, a short-timing instance, reset abort,
// back-to-back requests and random request gaps.
module tb_ppu_bbus_master;
  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   inv_fail;

  ppu_bbus_if b1();
  ppu_bbus_if b2();

  ppu_bbus_master dut (.clock(clock), .reset(reset), .bus(b1));
  ppu_bbus_master #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2))
    dut2 (.clock(clock), .reset(reset), .bus(b2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {pa, pd_out, pd_oe, pard_n, pawr_n, lvl_pa_dir, lvl_pd_dir, rsp_valid}
  function automatic logic [21:0] snap();
    return {b1.pa, b1.pd_out, b1.pd_oe, b1.pard_n, b1.pawr_n,
            b1.lvl_pa_dir, b1.lvl_pd_dir, b1.rsp_valid};
  endfunction

  localparam logic [21:0] RST_SNAP = {8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic [7:0] prev_pa;
  logic       prev_strb;
  always @(negedge clock) begin
    if (!reset) begin
      if (!b1.pard_n && !b1.pawr_n) begin
        $display("FAIL invariant_strobes: pard_n=%b pawr_n=%b, required not both 0", b1.pard_n, b1.pawr_n);
        inv_fail <= inv_fail + 1;
      end
      if (b1.pd_oe && !b1.lvl_pd_dir) begin
        $display("FAIL invariant_oe_dir: pd_oe=1 lvl_pd_dir=0, required pd_oe=0 when dir=0");
        inv_fail <= inv_fail + 1;
      end
      if (prev_strb && (!b1.pard_n || !b1.pawr_n) && b1.pa !== prev_pa) begin
        $display("FAIL invariant_pa_stable: pa=%h, required %h while strobe low", b1.pa, prev_pa);
        inv_fail <= inv_fail + 1;
      end
    end
    prev_pa   <= b1.pa;
    prev_strb <= !reset && (!b1.pard_n || !b1.pawr_n);
  end

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if (snap() !== RST_SNAP || b1.rsp_rdata !== 8'h00 || b1.req_ready !== 1'b0) begin
      $display("FAIL reset_state: snap=%h rdata=%h ready=%b, required snap=%h rdata=00 ready=0",
               snap(), b1.rsp_rdata, b1.req_ready, RST_SNAP);
      n_fail++;
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (b1.req_ready !== 1'b1 || b2.req_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: ready=%b/%b, required 1/1", b1.req_ready, b2.req_ready);
      n_fail++;
    end
  endtask

  task automatic test_write();
    logic [9:1] e_oe   = 9'b001111110;
    logic [9:1] e_pawr = 9'b111000011;
    logic [9:1] e_rsp  = 9'b001000000;
    logic [9:1] e_dir  = 9'b011111111;
    logic [9:1] e_rdy  = 9'b100000000;
    logic [21:0] exp;
    b1.req_write = 1'b1;
    b1.req_addr  = 8'h21;
    b1.req_wdata = 8'h0F;
    b1.req_valid = 1'b1;
    tick();
    b1.req_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      exp = {8'h21, 8'h0F, e_oe[k], 1'b1, e_pawr[k], e_dir[k], e_dir[k], e_rsp[k]};
      n_tests++;
      if (snap() !== exp || b1.req_ready !== e_rdy[k]) begin
        $display("FAIL write_cycle%0d: snap=%h ready=%b, required snap=%h ready=%b",
                 k, snap(), b1.req_ready, exp, e_rdy[k]);
        n_fail++;
      end
      if (k < 9) tick();
    end
  endtask

  task automatic test_read(input logic [7:0] addr, input logic [7:0] data);
    logic [9:1] e_pard = 9'b111000011;
    logic [9:1] e_rsp  = 9'b001000000;
    logic [9:1] e_dir  = 9'b011111111;
    logic [21:0] exp;
    b1.req_write = 1'b0;
    b1.req_addr  = addr;
    b1.req_wdata = 8'h77;
    b1.pd_in     = 8'hFF;
    b1.req_valid = 1'b1;
    tick();
    b1.req_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      b1.pd_in = (k >= 3 && k <= 6) ? data : 8'hFF;
      exp = {addr, 8'h77, 1'b0, e_pard[k], 1'b1, e_dir[k], 1'b0, e_rsp[k]};
      n_tests++;
      if (snap() !== exp) begin
        $display("FAIL read_%h_cycle%0d: snap=%h, required %h", addr, k, snap(), exp);
        n_fail++;
      end
      if (k == 7 || k == 9) begin
        n_tests++;
        if (b1.rsp_rdata !== data) begin
          $display("FAIL read_%h_rdata_c%0d: rdata=%h, required %h", addr, k, b1.rsp_rdata, data);
          n_fail++;
        end
      end
      if (k < 9) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa [3] = '{8'h10, 8'h11, 8'h12};
    logic [7:0] qd [3] = '{8'hA0, 8'hA1, 8'hA2};
    int acc_cyc [3];
    int idx = 0;
    int nrsp = 0;
    b1.req_write = 1'b1;
    b1.req_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (b1.rsp_valid) begin
        n_tests++;
        if (nrsp > 2 || b1.pa !== qa[nrsp] || b1.pd_out !== qd[nrsp]) begin
          $display("FAIL b2b_rsp%0d: pa=%h pd_out=%h, required queue order", nrsp, b1.pa, b1.pd_out);
          n_fail++;
        end
        nrsp++;
      end
      if (b1.req_ready && idx < 3) begin
        b1.req_addr  = qa[idx];
        b1.req_wdata = qd[idx];
        acc_cyc[idx] = cyc;
        idx++;
      end else begin
        b1.req_addr  = 8'hEE;
        b1.req_wdata = 8'h55;
        if (idx == 3) b1.req_valid = 1'b0;
      end
      tick();
    end
    b1.req_valid = 1'b0;
    n_tests++;
    if (idx != 3 || nrsp != 3) begin
      $display("FAIL b2b_counts: accepts=%0d rsps=%0d, required 3/3", idx, nrsp);
      n_fail++;
    end
    n_tests++;
    if (acc_cyc[1] - acc_cyc[0] != 9 || acc_cyc[2] - acc_cyc[1] != 9) begin
      $display("FAIL b2b_spacing: %0d %0d, required 9 9",
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      n_fail++;
    end
  endtask

  task automatic test_reset_abort();
    bit seen = 0;
    b1.req_write = 1'b1;
    b1.req_addr  = 8'h05;
    b1.req_wdata = 8'h99;
    b1.req_valid = 1'b1;
    tick();
    b1.req_valid = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (!b1.pawr_n) seen = 1;
      else tick();
    end
    n_tests++;
    if (!seen) begin
      $display("FAIL abort_strobe_timeout: pawr_n=%b, required 0 within 12 cycles", b1.pawr_n);
      n_fail++;
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if (snap() !== RST_SNAP || b1.rsp_rdata !== 8'h00 || b1.req_ready !== 1'b0) begin
      $display("FAIL abort_state: snap=%h rdata=%h ready=%b, required snap=%h rdata=00 ready=0",
               snap(), b1.rsp_rdata, b1.req_ready, RST_SNAP);
      n_fail++;
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (b1.req_ready !== 1'b1) begin
      $display("FAIL abort_ready: ready=%b, required 1", b1.req_ready);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (b1.rsp_valid !== 1'b0 || b1.pawr_n !== 1'b1) begin
        $display("FAIL abort_quiet%0d: rsp_valid=%b pawr_n=%b, required 0/1", i, b1.rsp_valid, b1.pawr_n);
        n_fail++;
      end
    end
    test_read(8'h3E, 8'hC3);
  endtask

  task automatic test_short_timing();
    logic [7:1] e_pawr = 7'b1110111;
    logic [7:1] e_rsp  = 7'b0010000;
    logic [7:1] e_oe   = 7'b0011110;
    logic [7:1] e_rdy  = 7'b1000000;
    b2.req_write = 1'b1;
    b2.req_addr  = 8'h44;
    b2.req_wdata = 8'h11;
    b2.req_valid = 1'b1;
    tick();
    b2.req_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      n_tests++;
      if ({b2.pawr_n, b2.rsp_valid, b2.pd_oe, b2.req_ready} !== {e_pawr[k], e_rsp[k], e_oe[k], e_rdy[k]}) begin
        $display("FAIL short_cycle%0d: pawr_n/rsp/oe/ready=%b%b%b%b, required %b%b%b%b", k,
                 b2.pawr_n, b2.rsp_valid, b2.pd_oe, b2.req_ready, e_pawr[k], e_rsp[k], e_oe[k], e_rdy[k]);
        n_fail++;
      end
      if (k < 7) tick();
    end
  endtask

  task automatic test_random_gaps();
    int acc = 0;
    int nrsp = 0;
    int last = -100;
    int bad_gap = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      b1.req_valid = ($urandom_range(0, 2) == 0);
      b1.req_write = 1'($urandom_range(0, 1));
      b1.req_addr  = 8'($urandom);
      b1.req_wdata = 8'($urandom);
      b1.pd_in     = 8'($urandom);
      if (b1.rsp_valid) nrsp++;
      if (b1.req_valid && b1.req_ready) begin
        if (cyc - last < 9) bad_gap++;
        last = cyc;
        acc++;
      end
      tick();
    end
    b1.req_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (b1.rsp_valid) nrsp++;
      tick();
    end
    n_tests++;
    if (acc == 0 || acc != nrsp || bad_gap != 0) begin
      $display("FAIL random_handshake: accepts=%0d rsps=%0d short_gaps=%0d, required accepts=rsps>0 gaps=0",
               acc, nrsp, bad_gap);
      n_fail++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    inv_fail = 0;
    reset = 1'b1;
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = 8'h00; b1.req_wdata = 8'h00; b1.pd_in = 8'hFF;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = 8'h00; b2.req_wdata = 8'h00; b2.pd_in = 8'hFF;
    test_reset();
    test_write();
    test_read(8'h3F, 8'h5A);
    test_back_to_back();
    test_reset_abort();
    test_short_timing();
    test_random_gaps();
    n_tests++;
    if (inv_fail != 0) begin
      $display("FAIL invariants: violations=%0d, required 0", inv_fail);
      n_fail++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
endmodule
